detector_jogada: RTL

- Input conditioning stage that sits directly upstream of the game datapath/FSM (`circuito_exp4` top) and feeds it its "jogada feita" event.
- Synchronizes and debounces the 4 `chaves` switches and validates that exactly one switch is pressed.
- Emits a single-cycle `jogada_valida` pulse with a registered one-hot code, then waits for release before accepting the next play.
- Replaces the raw edge detector on `chaves`, so a held or bouncing switch produces exactly one play.

---
 rtl/detector_jogada.sv | 136 +++++++++++++
 1 files changed

// File: rtl/detector_jogada.sv
// detector_jogada: input conditioning for the game FSM.
// Synchronizes the four raw switches, debounces a press until it has been
// stable for DEBOUNCE_CYCLES cycles, and classifies it. A single one-hot
// press gives one jogada_valida pulse. A press of two or more switches gives
// one jogada_invalida pulse. The block then waits for a debounced release
// before it accepts another play.
module detector_jogada #(
  parameter int unsigned DEBOUNCE_CYCLES = 3  // legal range 2..255
) (
  input  logic       clock,
  input  logic       reset,            // synchronous, active-high
  input  logic       habilita,         // 1 = game FSM expects a play
  input  logic [3:0] chaves,           // raw asynchronous switches
  output logic       jogada_valida,    // 1-cycle pulse: one-hot press accepted
  output logic       jogada_invalida,  // 1-cycle pulse: multi-switch press
  output logic [3:0] jogada,           // code of the last accepted play
  output logic       ocupado,          // 1 whenever not idle
  output logic [2:0] db_estado         // state encoding for the debug display
);

  typedef enum logic [2:0] {
    ESPERA   = 3'd0,
    FILTRA   = 3'd1,
    EMITE    = 3'd2,
    INVALIDA = 3'd3,
    SOLTA    = 3'd4
  } estado_e;

  localparam logic [7:0] CONT_ULTIMO = 8'(DEBOUNCE_CYCLES - 1);

  logic [3:0] s1_q;
  logic [3:0] s2_q;
  logic [3:0] amostra_q;
  logic [7:0] cont_q;
  estado_e    estado_q;
  logic [3:0] jogada_q;
  logic       valida_q;
  logic       invalida_q;
  logic       ocupado_q;

  // True when exactly one bit of the sample is set.
  function automatic logic eh_one_hot(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
  endfunction

  // Two-flop synchronizer on all switch bits; only s2_q is used downstream.
  always_ff @(posedge clock) begin
    // NOTE: every sequential assignment is non-blocking so that s2_q takes
    // the old s1_q. A blocking assignment here would collapse the two flops
    // into one.
    if (reset) begin
      s1_q <= 4'b0000;
      s2_q <= 4'b0000;
    end else begin
      s1_q <= chaves;
      s2_q <= s1_q;
    end
  end

  // Debounce/classify FSM. All outputs are registered and updated on the
  // same edge as the state transition that implies them.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q   <= ESPERA;
      amostra_q  <= 4'b0000;
      cont_q     <= 8'd0;
      jogada_q   <= 4'b0000;
      valida_q   <= 1'b0;
      invalida_q <= 1'b0;
      ocupado_q  <= 1'b0;
    end else begin
      // Pulses default low; they are only raised on the edge entering
      // EMITE/INVALIDA. Those states always leave on the next edge, so each
      // pulse lasts exactly one cycle.
      valida_q   <= 1'b0;
      invalida_q <= 1'b0;
      case (estado_q)
        ESPERA: begin
          if (habilita && (s2_q != 4'b0000)) begin
            estado_q  <= FILTRA;
            ocupado_q <= 1'b1;
            amostra_q <= s2_q;
            cont_q    <= 8'd0;
          end
        end
        FILTRA: begin
          if (!habilita || (s2_q == 4'b0000)) begin
            estado_q  <= ESPERA;
            ocupado_q <= 1'b0;
          end else if (s2_q != amostra_q) begin
            // The pattern changed mid-filter, so restart on the new pattern.
            amostra_q <= s2_q;
            cont_q    <= 8'd0;
          end else if (cont_q == CONT_ULTIMO) begin
            if (eh_one_hot(amostra_q)) begin
              estado_q <= EMITE;
              jogada_q <= amostra_q;
              valida_q <= 1'b1;
            end else begin
              estado_q   <= INVALIDA;
              invalida_q <= 1'b1;
            end
          end else begin
            cont_q <= cont_q + 8'd1;
          end
        end
        EMITE, INVALIDA: begin
          estado_q <= SOLTA;
          cont_q   <= 8'd0;
        end
        SOLTA: begin
          // habilita is ignored here: a full release must be seen first.
          if (s2_q != 4'b0000) begin
            cont_q <= 8'd0;
          end else if (cont_q == CONT_ULTIMO) begin
            estado_q  <= ESPERA;
            ocupado_q <= 1'b0;
          end else begin
            cont_q <= cont_q + 8'd1;
          end
        end
        default: begin
          estado_q  <= ESPERA;
          ocupado_q <= 1'b0;
        end
      endcase
    end
  end

  assign jogada_valida   = valida_q;
  assign jogada_invalida = invalida_q;
  assign jogada          = jogada_q;
  assign ocupado         = ocupado_q;
  assign db_estado       = estado_q;

endmodule
